psram_responder: RTL

//  Synchronous target model of one asynchronous PSRAM bank on the cram_* bus: answers the multiplexed

---
 rtl/psram_pkg.sv | 17 +
 rtl/psram_responder_if.sv | 37 +++
 rtl/psram_responder_mem.sv | 25 ++
 rtl/psram_responder.sv | 135 +++++++++++++
 4 files changed

// File: rtl/psram_pkg.sv
// Shared types for the PSRAM responder: FSM state encoding, byte-enable lanes, latency bound.
package psram_pkg;

  localparam int unsigned MAX_READ_LATENCY = 6;
  localparam int unsigned LAT_BITS         = $clog2(MAX_READ_LATENCY + 1);

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StRead,
    StWrite
  } state_t;

  // {upper, lower} byte enables, active high.
  typedef logic [1:0] be_t;

endpackage

// File: rtl/psram_responder_if.sv
// cram_* bus between a PSRAM controller (master) and the responder (slave).
// The shared DQ wire is resolved here: the responder's drive wins while dq_oe is high.
interface psram_responder_if #(
  parameter int unsigned ADDRESS_BITS = 23,
  parameter int unsigned DATA_BITS    = 16
);

  logic [ADDRESS_BITS-DATA_BITS-2:0] cram_a;
  logic [DATA_BITS-1:0]              dq_host;
  logic [DATA_BITS-1:0]              dq_drv;
  logic                              dq_oe;
  logic [DATA_BITS-1:0]              cram_dq;
  logic                              cram_wait;
  logic                              cram_clk;
  logic                              cram_adv_n;
  logic                              cram_cre;
  logic                              cram_ce_n;
  logic                              cram_oe_n;
  logic                              cram_we_n;
  logic                              cram_ub_n;
  logic                              cram_lb_n;

  assign cram_dq = dq_oe ? dq_drv : dq_host;

  modport master (
    output cram_a, dq_host, cram_clk, cram_adv_n, cram_cre, cram_ce_n, cram_oe_n, cram_we_n,
           cram_ub_n, cram_lb_n,
    input  cram_dq, dq_drv, dq_oe, cram_wait
  );

  modport slave (
    input  cram_a, cram_dq, cram_clk, cram_adv_n, cram_cre, cram_ce_n, cram_oe_n, cram_we_n,
           cram_ub_n, cram_lb_n,
    output dq_drv, dq_oe, cram_wait
  );

endinterface

// File: rtl/psram_responder_mem.sv
// Byte-masked single-port synchronous RAM with a one-cycle registered read.
module psram_responder_mem #(
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned DATA_BITS = 16
) (
  input  logic                   clk_i,
  input  logic                   we_i,
  input  logic [DATA_BITS/8-1:0] be_i,
  input  logic [ADDR_BITS-1:0]   addr_i,
  input  logic [DATA_BITS-1:0]   wdata_i,
  output logic [DATA_BITS-1:0]   rdata_o
);

  logic [DATA_BITS-1:0] mem_q [2**ADDR_BITS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < DATA_BITS / 8; i++) begin
        if (be_i[i]) mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
      end
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/psram_responder.sv
// Synchronous target model of one async PSRAM bank on the cram_* bus.
// Build option PSRAM_RESPONDER_PROTOCOL_CHECK_EN enables the sticky protocol_error checker.
module psram_responder
  import psram_pkg::*;
#(
  parameter int unsigned ADDRESS_BITS  = 23,
  parameter int unsigned DATA_BITS     = 16,
  parameter int unsigned MEM_ADDR_BITS = 10,
  parameter int unsigned READ_LATENCY  = 2,
  parameter int unsigned BANK          = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  psram_responder_if.slave       bus,
  output logic                   busy,
  output logic                   protocol_error
);

  if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
    $error("READ_LATENCY out of range 1..6");
  end

  localparam logic [LAT_BITS-1:0] LatMax = LAT_BITS'(READ_LATENCY);

  state_t                  state_q, state_d;
  logic [ADDRESS_BITS-2:0] addr_q, addr_d;
  logic [DATA_BITS-1:0]    wd_q, wd_d;
  be_t                     be_q, be_d;
  logic [LAT_BITS-1:0]     lat_q, lat_d;
  logic                    mem_we;
  logic [DATA_BITS-1:0]    rd_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    be_d    = be_q;
    lat_d   = lat_q;
    mem_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!bus.cram_ce_n && !bus.cram_adv_n && !bus.cram_cre) begin
          addr_d  = {bus.cram_a, bus.cram_dq};
          be_d    = '0;  // a write cycle with no data phase leaves the array untouched
          state_d = bus.cram_we_n ? StAddr : StWrite;
        end
      end
      StAddr: begin
        if (bus.cram_ce_n) begin
          state_d = StIdle;
        end else if (!bus.cram_oe_n && bus.cram_we_n) begin
          state_d = StRead;
          lat_d   = LAT_BITS'(1);
        end
      end
      StRead: begin
        if (bus.cram_ce_n) begin
          state_d = StIdle;
        end else if (!bus.cram_oe_n && lat_q != LatMax) begin
          lat_d = lat_q + LAT_BITS'(1);
        end
      end
      StWrite: begin
        if (bus.cram_ce_n) begin
          mem_we  = 1'b1;
          state_d = StIdle;
        end else if (bus.cram_adv_n && !bus.cram_we_n) begin
          wd_d = bus.cram_dq;
          be_d = {~bus.cram_ub_n, ~bus.cram_lb_n};
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wd_q    <= '0;
      be_q    <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      be_q    <= be_d;
      lat_q   <= lat_d;
    end
  end

  psram_responder_mem #(
    .ADDR_BITS(MEM_ADDR_BITS),
    .DATA_BITS(DATA_BITS)
  ) u_mem (
    .clk_i  (clk),
    .we_i   (mem_we),
    .be_i   (be_q),
    .addr_i (addr_q[MEM_ADDR_BITS-1:0]),
    .wdata_i(wd_q),
    .rdata_o(rd_q)
  );

  // Enable is combinational so OE# rising or reset releases the bus within the cycle;
  // WE# low alongside OE# is a write-abort and never drives.
  assign bus.dq_oe     = (state_q == StRead) && (lat_q == LatMax) && !bus.cram_oe_n &&
                         bus.cram_we_n;
  assign bus.dq_drv    = rd_q;
  assign bus.cram_wait = 1'b0;
  assign busy          = (state_q != StIdle);

`ifdef PSRAM_RESPONDER_PROTOCOL_CHECK_EN
  logic err_q;
  logic err_hit;

  assign err_hit = (!bus.cram_oe_n && !bus.cram_we_n && !bus.cram_ce_n) ||
                   (!bus.cram_adv_n && bus.cram_ce_n) ||
                   (!bus.cram_adv_n && state_q != StIdle) ||
                   (bus.cram_cre && !bus.cram_ce_n) ||
                   (!bus.cram_oe_n && state_q == StWrite);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_q | err_hit;
  end

  assign protocol_error = err_q;
`else
  assign protocol_error = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{bus.cram_clk, addr_q[ADDRESS_BITS-2:MEM_ADDR_BITS]};

endmodule
